// File: rtl/axi_stream_header_arbiter.sv
// ---------------------------------------------------------------------------
// axi_stream_header_arbiter
//
// Shares the single header port of an AXI-Stream header inserter between
// NUM_REQ header sources. Arbitration is round-robin and one grant covers
// exactly one packet. The granted header and keep are captured and offered
// to the inserter. The next grant is held off until the inserter's output
// shows its end-of-packet beat. A stall watchdog releases a packet whose
// output has stopped moving.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   req_valid       per-requester header valid
//   req_header      requester i header at [i*DATA_WD +: DATA_WD]
//   req_keep        requester i keep at [i*DATA_BYTE_WD +: DATA_BYTE_WD]
//   req_ready       one-hot accept of the winning requester (IDLE only)
//   valid_insert    header valid to the inserter
//   header_insert   captured header
//   keep_insert     captured keep
//   ready_insert    inserter accepts the header
//   mon_valid/ready/last  monitor of the inserter output handshake
//   grant_id        index of the current or last granted requester
//   busy            high while a packet is offered or in flight
//   pkt_cnt         completed packets, wraps at 16 bits
//   err_keep        one-cycle pulse: illegal keep was dropped
//   err_timeout     one-cycle pulse: watchdog released a packet
// ---------------------------------------------------------------------------
module axi_stream_header_arbiter #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int NUM_REQ      = 4,
  parameter int ID_WD        = 2,
  parameter int TIMEOUT_CYC  = 1024
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*DATA_WD-1:0]      req_header,
  input  logic [NUM_REQ*DATA_BYTE_WD-1:0] req_keep,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            valid_insert,
  output logic [DATA_WD-1:0]              header_insert,
  output logic [DATA_BYTE_WD-1:0]         keep_insert,
  input  logic                            ready_insert,
  input  logic                            mon_valid,
  input  logic                            mon_ready,
  input  logic                            mon_last,
  output logic [ID_WD-1:0]                grant_id,
  output logic                            busy,
  output logic [15:0]                     pkt_cnt,
  output logic                            err_keep,
  output logic                            err_timeout
);

  // Watchdog counter only has to reach TIMEOUT_CYC-1.
  localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WD_W-1:0] WD_LIMIT = (TIMEOUT_CYC > 0) ? WD_W'(TIMEOUT_CYC - 1) : '0;
  localparam bit WD_EN = (TIMEOUT_CYC > 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OFFER = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  // Legal keep is a run of ones from the LSB (including all zero):
  // adding one turns it into a power of two, so no bit overlaps.
  function automatic logic f_keep_legal(input logic [DATA_BYTE_WD-1:0] k);
    logic [DATA_BYTE_WD-1:0] k_inc;
    k_inc = k + DATA_BYTE_WD'(1);
    return ((k & k_inc) == '0);
  endfunction

  // First set request scanning upward from the pointer, with wrap.
  function automatic logic [ID_WD-1:0] f_pick(input logic [NUM_REQ-1:0] v,
                                               input logic [ID_WD-1:0]   p);
    logic             found;
    logic [ID_WD-1:0] w;
    int               idx;
    found = 1'b0;
    w     = p;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx   = (int'(p) + i) % NUM_REQ;
      w     = (!found && v[idx]) ? ID_WD'(idx) : w;
      found = found | v[idx];
    end
    return w;
  endfunction

  // Pointer increment modulo NUM_REQ (NUM_REQ need not be a power of two).
  function automatic logic [ID_WD-1:0] f_ptr_inc(input logic [ID_WD-1:0] p);
    return (int'(p) == NUM_REQ - 1) ? '0 : (p + ID_WD'(1));
  endfunction

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [ID_WD-1:0]         r_rr_ptr;
  logic [ID_WD-1:0]         r_grant_id;
  logic                     r_valid_insert;
  logic [DATA_WD-1:0]       r_header;
  logic [DATA_BYTE_WD-1:0]  r_keep;
  logic                     r_busy;
  logic [15:0]              r_pkt_cnt;
  logic                     r_err_keep;
  logic                     r_err_timeout;
  logic [WD_W-1:0]          r_wd_cnt;

  logic                     w_grant;
  logic [ID_WD-1:0]         w_winner;
  logic [DATA_WD-1:0]       w_hdr_sel;
  logic [DATA_BYTE_WD-1:0]  w_keep_sel;
  logic                     w_keep_ok;
  logic                     w_hs;
  logic                     w_beat;
  logic                     w_eop;
  logic                     w_wd_expire;

  // req_ready is combinational, so it is also gated by reset to keep
  // every output at zero while rst_n is low.
  assign w_grant     = rst_n && (r_state == ST_IDLE) && (|req_valid);
  assign w_winner    = f_pick(req_valid, r_rr_ptr);
  assign w_hdr_sel   = req_header[int'(w_winner)*DATA_WD +: DATA_WD];
  assign w_keep_sel  = req_keep[int'(w_winner)*DATA_BYTE_WD +: DATA_BYTE_WD];
  assign w_keep_ok   = f_keep_legal(w_keep_sel);
  assign w_hs        = r_valid_insert & ready_insert;
  assign w_beat      = mon_valid & mon_ready;
  assign w_eop       = w_beat & mon_last;
  // Any output beat restarts the count, so expiry only without a beat.
  assign w_wd_expire = WD_EN && !w_beat && (r_wd_cnt == WD_LIMIT);

  // One-hot accept of the winning requester.
  always_comb begin
    req_ready = '0;
    if (w_grant) begin
      req_ready[w_winner] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        // Illegal keep consumes the request but offers nothing.
        if (w_grant && w_keep_ok) begin
          w_state_nxt = ST_OFFER;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_OFFER: begin
        if (w_hs) begin
          w_state_nxt = ST_WAIT;
        end else begin
          w_state_nxt = ST_OFFER;
        end
      end
      ST_WAIT: begin
        // End of packet has priority over a same-cycle watchdog expiry.
        if (w_eop) begin
          w_state_nxt = ST_IDLE;
        end else if (w_wd_expire) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register with the status flags derived from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_busy         <= 1'b0;
      r_valid_insert <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_busy         <= (w_state_nxt != ST_IDLE);
      r_valid_insert <= (w_state_nxt == ST_OFFER);
    end
  end

  // Grant bookkeeping: round-robin pointer, grant index, captured header.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
      r_header   <= '0;
      r_keep     <= '0;
    end else if (w_grant) begin
      r_rr_ptr   <= f_ptr_inc(w_winner);
      r_grant_id <= w_winner;
      if (w_keep_ok) begin
        r_header <= w_hdr_sel;
        r_keep   <= w_keep_sel;
      end
    end
  end

  // Error pulses, each high for exactly one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_keep    <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_err_keep    <= w_grant & ~w_keep_ok;
      r_err_timeout <= (r_state == ST_WAIT) & ~w_eop & w_wd_expire;
    end
  end

  // Completed packet counter, wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pkt_cnt <= 16'd0;
    end else if ((r_state == ST_WAIT) && w_eop) begin
      r_pkt_cnt <= r_pkt_cnt + 16'd1;
    end
  end

  // Watchdog: held at zero outside WAIT_EOP so it starts clean on entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wd_cnt <= '0;
    end else if (r_state != ST_WAIT) begin
      r_wd_cnt <= '0;
    end else if (w_beat || w_wd_expire) begin
      r_wd_cnt <= '0;
    end else begin
      r_wd_cnt <= r_wd_cnt + WD_W'(1);
    end
  end

  assign valid_insert  = r_valid_insert;
  assign header_insert = r_header;
  assign keep_insert   = r_keep;
  assign grant_id      = r_grant_id;
  assign busy          = r_busy;
  assign pkt_cnt       = r_pkt_cnt;
  assign err_keep      = r_err_keep;
  assign err_timeout   = r_err_timeout;

endmodule
